// File: rtl/output_timing_gen_pkg.sv
// Shared timing defaults for the output timing generator: default 1280x720
// raster, source content size, repeat factors and line-buffer depth.
package output_timing_gen_pkg;

    localparam int DEF_H_TOTAL     = 1650;
    localparam int DEF_H_ACTIVE    = 1280;
    localparam int DEF_H_SYNCLEN   = 40;
    localparam int DEF_H_BACKPORCH = 220;
    localparam int DEF_V_TOTAL     = 750;
    localparam int DEF_V_ACTIVE    = 720;
    localparam int DEF_V_SYNCLEN   = 5;
    localparam int DEF_V_BACKPORCH = 20;
    localparam int DEF_H_MULT      = 3;
    localparam int DEF_V_MULT      = 3;
    localparam int DEF_H_SRC       = 384;
    localparam int DEF_V_SRC       = 224;
    localparam int DEF_NUM_LBUF    = 40;

    // Offset that centres scaled content inside the active area.
    function automatic int centre_offset(input int active, input int src, input int mult);
        return (active - src * mult) / 2;
    endfunction

endpackage

// File: rtl/output_timing_gen_repeat_ctr.sv
// Repeat counter: a phase counter cycling 0..phase_last and an index counter
// that advances each time the phase wraps, wrapping itself after idx_last.
// clr has priority over en and forces both counters to zero.
module repeat_ctr #(
    parameter int PH_W  = 3,
    parameter int IDX_W = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [PH_W-1:0]  phase_last,
    input  logic [IDX_W-1:0] idx_last,
    output logic [PH_W-1:0]  phase,
    output logic [IDX_W-1:0] idx
);

    logic [PH_W-1:0]  phase_q, phase_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    // Next phase/index: clear, hold, or advance with nested wrap.
    always_comb begin
        phase_d = phase_q;
        idx_d   = idx_q;
        if (clr) begin
            phase_d = '0;
            idx_d   = '0;
        end else if (en) begin
            if (phase_q == phase_last) begin
                phase_d = '0;
                idx_d   = (idx_q == idx_last) ? '0 : idx_q + IDX_W'(1);
            end else begin
                phase_d = phase_q + PH_W'(1);
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
            idx_q   <= '0;
        end else begin
            phase_q <= phase_d;
            idx_q   <= idx_d;
        end
    end

    assign phase = phase_q;
    assign idx   = idx_q;

endmodule

// File: rtl/output_timing_gen.sv
// Output raster timing generator. The next raster position is computed
// combinationally and every output is derived from that next position, then
// registered on the same edge, so all outputs describe one (hcnt,vcnt).
module output_timing_gen
    import output_timing_gen_pkg::*;
#(
    parameter int H_TOTAL     = DEF_H_TOTAL,
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int H_SYNCLEN   = DEF_H_SYNCLEN,
    parameter int H_BACKPORCH = DEF_H_BACKPORCH,
    parameter int V_TOTAL     = DEF_V_TOTAL,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int V_SYNCLEN   = DEF_V_SYNCLEN,
    parameter int V_BACKPORCH = DEF_V_BACKPORCH,
    parameter int H_MULT      = DEF_H_MULT,
    parameter int V_MULT      = DEF_V_MULT,
    parameter int H_SRC       = DEF_H_SRC,
    parameter int V_SRC       = DEF_V_SRC,
    parameter int NUM_LBUF    = DEF_NUM_LBUF
) (
    input  logic        PCLK_in,
    input  logic        reset_n,
    input  logic        frame_sync,
    input  logic        lock_en,
    output logic [10:0] hcnt,
    output logic [10:0] vcnt,
    output logic [8:0]  hcnt_lbuf,
    output logic [5:0]  vcnt_lbuf,
    output logic [2:0]  hctr,
    output logic [2:0]  vctr,
    output logic        HSYNC,
    output logic        VSYNC,
    output logic        DE,
    output logic        mask_enable,
    output logic        frame_start
);

    localparam int H_AVS = H_SYNCLEN + H_BACKPORCH;
    localparam int V_AVS = V_SYNCLEN + V_BACKPORCH;
    localparam int H_CS  = H_AVS + centre_offset(H_ACTIVE, H_SRC, H_MULT);
    localparam int V_CS  = V_AVS + centre_offset(V_ACTIVE, V_SRC, V_MULT);

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_SYNC_E = 11'(H_SYNCLEN);
    localparam logic [10:0] V_SYNC_E = 11'(V_SYNCLEN);
    localparam logic [10:0] H_ACT_S  = 11'(H_AVS);
    localparam logic [10:0] H_ACT_E  = 11'(H_AVS + H_ACTIVE - 1);
    localparam logic [10:0] V_ACT_S  = 11'(V_AVS);
    localparam logic [10:0] V_ACT_E  = 11'(V_AVS + V_ACTIVE - 1);
    localparam logic [10:0] H_WIN_S  = 11'(H_CS);
    localparam logic [10:0] H_WIN_E  = 11'(H_CS + H_SRC * H_MULT - 1);
    localparam logic [10:0] V_WIN_S  = 11'(V_CS);
    localparam logic [10:0] V_WIN_E  = 11'(V_CS + V_SRC * V_MULT - 1);

    logic [10:0] hcnt_q, hcnt_d;
    logic [10:0] vcnt_q, vcnt_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        de_q, de_d;
    logic        mask_q, mask_d;
    logic        fstart_q, fstart_d;
    logic        resync;
    logic        h_win, v_win;
    logic        h_adv, h_clr;
    logic        v_adv, v_clr;

    assign resync = frame_sync & lock_en;

    // Next raster position; a locked frame_sync overrides any increment or wrap.
    always_comb begin
        hcnt_d = hcnt_q + 11'd1;
        vcnt_d = vcnt_q;
        if (resync) begin
            hcnt_d = '0;
            vcnt_d = '0;
        end else if (hcnt_q == H_LAST) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 11'd1;
        end
    end

    // Syncs, enables and repeat-counter controls, all from the next position.
    always_comb begin
        h_win    = (hcnt_d >= H_WIN_S) && (hcnt_d <= H_WIN_E);
        v_win    = (vcnt_d >= V_WIN_S) && (vcnt_d <= V_WIN_E);
        hsync_d  = !(hcnt_d < H_SYNC_E);
        vsync_d  = !(vcnt_d < V_SYNC_E);
        de_d     = (hcnt_d >= H_ACT_S) && (hcnt_d <= H_ACT_E) &&
                   (vcnt_d >= V_ACT_S) && (vcnt_d <= V_ACT_E);
        mask_d   = de_d && !(h_win && v_win);
        fstart_d = (hcnt_d == 11'd0) && (vcnt_d == 11'd0);
        // Horizontal phase restarts on the first window pixel, runs inside it.
        h_adv    = h_win && (hcnt_d != H_WIN_S);
        h_clr    = !h_adv;
        // Vertical phase restarts on the first window line, advances per new line.
        v_adv    = (hcnt_d == 11'd0) && v_win && (vcnt_d != V_WIN_S);
        v_clr    = !v_win || (vcnt_d == V_WIN_S);
    end

    // Position and flag registers.
    always_ff @(posedge PCLK_in or negedge reset_n) begin
        if (!reset_n) begin
            hcnt_q   <= '0;
            vcnt_q   <= '0;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            de_q     <= 1'b0;
            mask_q   <= 1'b0;
            fstart_q <= 1'b0;
        end else begin
            hcnt_q   <= hcnt_d;
            vcnt_q   <= vcnt_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            de_q     <= de_d;
            mask_q   <= mask_d;
            fstart_q <= fstart_d;
        end
    end

    repeat_ctr #(.PH_W(3), .IDX_W(9)) u_hrep (
        .clk        (PCLK_in),
        .rst_n      (reset_n),
        .en         (h_adv),
        .clr        (h_clr),
        .phase_last (3'(H_MULT - 1)),
        .idx_last   (9'(H_SRC - 1)),
        .phase      (hctr),
        .idx        (hcnt_lbuf)
    );

    repeat_ctr #(.PH_W(3), .IDX_W(6)) u_vrep (
        .clk        (PCLK_in),
        .rst_n      (reset_n),
        .en         (v_adv),
        .clr        (v_clr),
        .phase_last (3'(V_MULT - 1)),
        .idx_last   (6'(NUM_LBUF - 1)),
        .phase      (vctr),
        .idx        (vcnt_lbuf)
    );

    assign hcnt        = hcnt_q;
    assign vcnt        = vcnt_q;
    assign HSYNC       = hsync_q;
    assign VSYNC       = vsync_q;
    assign DE          = de_q;
    assign mask_enable = mask_q;
    assign frame_start = fstart_q;

endmodule
